ipu_frame_sequencer: RTL and testbench

//  Parametrised frame-scan controller for the image processing unit (IPU). Replaces the fixed 512x480 scan

---
 rtl/ipu_pkg.sv | 25 ++
 rtl/ipu_row_loader.sv | 49 ++++
 rtl/ipu_frame_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_ipu_frame_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ipu_pkg.sv
// Shared types and constants for the IPU frame sequencer: FSM states, opcodes, kernel size helper.
package ipu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_ROW_LOAD,
    ST_DONE
  } ipu_state_t;

  localparam logic [3:0] OPC_CONV         = 4'b0101;
  localparam logic [3:0] OPC_CONV_TRSP    = 4'b0110;
  localparam logic [3:0] OPC_CONV_ROB     = 4'b0111;
  localparam logic [3:0] OPC_PHOTO_CONV   = 4'b1110;
  localparam logic [3:0] OPC_CONVERT_GREY = 4'b1100;

  // Kernel height in rows: code 0..3 maps to 2..5.
  function automatic logic [2:0] k_from_ksize(input logic [1:0] ksize);
    return 3'(ksize) + 3'd2;
  endfunction

endpackage

// File: rtl/ipu_row_loader.sv
// Row loader: walks h_load/v_load across the frame one memory word per load_row strobe
// and presents the word address of the row being loaded.
module ipu_row_loader #(
  parameter int IMG_W        = 512,
  parameter int COORD_W      = 9,
  parameter int PIX_PER_WORD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load_row,
  output logic [2*COORD_W-3:0] buf_addr,
  output logic [COORD_W-1:0]   v_load,
  output logic                 row_done
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(IMG_W - PIX_PER_WORD);
  localparam logic [COORD_W-1:0] H_STEP = COORD_W'(PIX_PER_WORD);

  logic [COORD_W-1:0] h_load_reg;
  logic [COORD_W-1:0] v_load_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      h_load_reg <= '0;
      v_load_reg <= '0;
    end else if (load_row) begin
      if (h_load_reg == H_LAST) begin
        h_load_reg <= '0;
        v_load_reg <= v_load_reg + 1'b1;
      end else begin
        h_load_reg <= h_load_reg + H_STEP;
      end
    end
  end

  assign row_done = load_row && (h_load_reg == H_LAST);
  assign v_load   = v_load_reg;

  // Word address drops the two pixel-within-word bits of h_load.
  genvar gi;
  generate
    for (gi = 0; gi < COORD_W - 2; gi++) begin : g_haddr
      assign buf_addr[gi] = h_load_reg[gi+2];
    end
  endgenerate
  assign buf_addr[2*COORD_W-3:COORD_W-2] = v_load_reg;

endmodule

// File: rtl/ipu_frame_sequencer.sv
// Frame-scan controller: primes line buffers, issues one convolution request per pixel, reloads rows.
// Optional stall counter output enabled by defining IPU_STALL_CNT_EN.
module ipu_frame_sequencer
  import ipu_pkg::*;
#(
  parameter int IMG_W        = 512,
  parameter int IMG_H        = 480,
  parameter int COORD_W      = 9,
  parameter int PIX_PER_WORD = 4,
  parameter int OPC_W        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [OPC_W-1:0]           opcode_in,
  input  logic [1:0]                 ksize,
  output logic [2*COORD_W-3:0]       buf_addr,
  output logic                       buf_load,
  output logic                       buf_start,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [2*COORD_W+OPC_W-1:0] req_inst,
  input  logic                       conv_done,
  output logic                       next_matrix,
  output logic                       busy,
  output logic                       frame_done
`ifdef IPU_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam logic [COORD_W-1:0] H_CONV_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] V_CONV_LAST = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] V_LOAD_END  = COORD_W'(IMG_H);

  ipu_state_t         state_reg, state_next;
  logic [OPC_W-1:0]   opcode_reg, opcode_next;
  logic [2:0]         rows_left_reg, rows_left_next;
  logic [COORD_W-1:0] h_conv_reg, h_conv_next;
  logic [COORD_W-1:0] v_conv_reg, v_conv_next;
  logic               start_d_reg;

  logic               start_accept;
  logic               load_row;
  logic               clr_load;
  logic               row_done;
  logic [COORD_W-1:0] v_load;

  ipu_row_loader #(
    .IMG_W       (IMG_W),
    .COORD_W     (COORD_W),
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_row_loader (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_load),
    .load_row(load_row),
    .buf_addr(buf_addr),
    .v_load  (v_load),
    .row_done(row_done)
  );

  assign start_accept = (state_reg == ST_IDLE) && start && !start_d_reg && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      opcode_reg    <= '0;
      rows_left_reg <= '0;
      h_conv_reg    <= '0;
      v_conv_reg    <= '0;
      start_d_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      opcode_reg    <= opcode_next;
      rows_left_reg <= rows_left_next;
      h_conv_reg    <= h_conv_next;
      v_conv_reg    <= v_conv_next;
      start_d_reg   <= start;
    end
  end

  always_comb begin
    state_next     = state_reg;
    opcode_next    = opcode_reg;
    rows_left_next = rows_left_reg;
    h_conv_next    = h_conv_reg;
    v_conv_next    = v_conv_reg;
    load_row       = 1'b0;
    clr_load       = 1'b0;
    buf_start      = 1'b0;
    req_valid      = 1'b0;
    next_matrix    = 1'b0;
    frame_done     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_accept) begin
          opcode_next    = opcode_in;
          rows_left_next = k_from_ksize(ksize) - 3'd1;
          state_next     = ST_PRELOAD;
        end
      end
      ST_PRELOAD: begin
        load_row  = 1'b1;
        buf_start = 1'b1;
        if (row_done) begin
          if (rows_left_reg == 3'd0) state_next = ST_ISSUE;
          else rows_left_next = rows_left_reg - 3'd1;
        end
      end
      ST_ROW_LOAD: begin
        // Once every frame row is in the buffers there is nothing left to fetch.
        if (v_load == V_LOAD_END) begin
          state_next = ST_ISSUE;
        end else begin
          load_row  = 1'b1;
          buf_start = 1'b1;
          if (row_done) state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (conv_done) state_next = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        next_matrix = 1'b1;
        if (h_conv_reg != H_CONV_LAST) begin
          h_conv_next = h_conv_reg + 1'b1;
          state_next  = ST_ISSUE;
        end else if (v_conv_reg != V_CONV_LAST) begin
          h_conv_next = '0;
          v_conv_next = v_conv_reg + 1'b1;
          state_next  = ST_ROW_LOAD;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done     = 1'b1;
        clr_load       = 1'b1;
        opcode_next    = '0;
        rows_left_next = '0;
        h_conv_next    = '0;
        v_conv_next    = '0;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle conv_done or start.
    if (abort) begin
      state_next     = ST_IDLE;
      opcode_next    = '0;
      rows_left_next = '0;
      h_conv_next    = '0;
      v_conv_next    = '0;
      clr_load       = 1'b1;
      load_row       = 1'b0;
      buf_start      = 1'b0;
      req_valid      = 1'b0;
      next_matrix    = 1'b0;
      frame_done     = 1'b0;
    end
  end

  assign buf_load = load_row;
  assign req_inst = {v_conv_reg, h_conv_reg, opcode_reg};
  assign busy     = (state_reg != ST_IDLE) && !abort;

`ifdef IPU_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || start_accept) begin
      stall_cnt_reg <= '0;
    end else if ((req_valid && !req_ready) || (state_reg == ST_WAIT_DONE)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ipu_frame_sequencer.sv
// Randomized bench for ipu_frame_sequencer on a 16x4 frame against a raster-order event model.
module tb_ipu_frame_sequencer;
  import ipu_pkg::*;

  localparam int W      = 16;
  localparam int H      = 4;
  localparam int CW     = 9;
  localparam int PPW    = 4;
  localparam int OW     = 4;
  localparam int WPR    = W / PPW;
  localparam int BUDGET = 5000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [OW-1:0]       opcode_in;
  logic [1:0]          ksize;
  logic [2*CW-3:0]     buf_addr;
  logic                buf_load;
  logic                buf_start;
  logic                req_valid;
  logic                req_ready;
  logic [2*CW+OW-1:0]  req_inst;
  logic                conv_done;
  logic                next_matrix;
  logic                busy;
  logic                frame_done;
`ifdef IPU_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  opc_tab[5] = '{OPC_CONV, OPC_CONV_TRSP, OPC_CONV_ROB, OPC_PHOTO_CONV, OPC_CONVERT_GREY};

  always #5 clk = ~clk;

  ipu_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .COORD_W(CW), .PIX_PER_WORD(PPW), .OPC_W(OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .opcode_in  (opcode_in),
    .ksize      (ksize),
    .buf_addr   (buf_addr),
    .buf_load   (buf_load),
    .buf_start  (buf_start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_inst   (req_inst),
    .conv_done  (conv_done),
    .next_matrix(next_matrix),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef IPU_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected event stream for a frame: row loads (tag 0) and accepted requests (tag 1) in order.
  task automatic build_model(input int k, input logic [3:0] opc);
    int next_row;
    exp_q.delete();
    for (int r = 0; r < k; r++)
      for (int w = 0; w < WPR; w++) exp_q.push_back(32'(r * (1 << (CW - 2)) + w));
    next_row = k;
    for (int v = 0; v < H; v++) begin
      for (int h = 0; h < W; h++)
        exp_q.push_back(32'h8000_0000 | 32'(v * (1 << (CW + OW)) + h * (1 << OW) + int'(opc)));
      if (v < H - 1 && next_row < H) begin
        for (int w = 0; w < WPR; w++) exp_q.push_back(32'(next_row * (1 << (CW - 2)) + w));
        next_row++;
      end
    end
  endtask

  task automatic run_frame(input int ks, input logic [3:0] opc, input bit stall_first);
    int k = ks + 2;
    int cyc = 0, nm = 0, fd = 0, pend = -1, stall_left, last_nm = 0, gap_exp = 0;
    bit done = 0, first_req = 1, holding = 0, gap_pend = 0, rdy;
    logic [31:0] held = '0, e;
    stall_left = stall_first ? 5 : 0;
    build_model(k, opc);
    @(negedge clk);
    start = 1'b0; ksize = 2'(ks); opcode_in = opc;
    @(negedge clk);
    start = 1'b1;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      conv_done = 1'b0;
      if (buf_load) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check_eq("load_addr", {16'h0, buf_addr}, e);
        check_eq("load_start", 32'(buf_start), 32'd1);
      end
      if (holding) begin
        check_eq("hold_valid", 32'(req_valid), 32'd1);
        check_eq("hold_inst", 32'(req_inst), held);
      end
      if (req_valid && first_req) begin
        check_eq("first_req_lat", 32'(cyc), 32'(k * WPR + 1));
        first_req = 0;
      end
      if (req_valid && gap_pend) begin
        check_eq("issue_gap", 32'(cyc - last_nm), 32'(gap_exp));
        gap_pend = 0;
      end
      if (next_matrix) begin
        nm++;
        if (nm < W * H) begin
          gap_pend = 1;
          last_nm  = cyc;
          if (nm % W != 0) gap_exp = 1;
          else gap_exp = (k + nm / W - 1 < H) ? WPR + 1 : 2;
        end
      end
      if (frame_done) begin
        fd++;
        done = 1;
      end
      // Coprocessor model: drive ready and the delayed result for the next edge.
      if (pend == 0) begin
        conv_done = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (req_valid) begin
        if (stall_left > 0) begin
          rdy = 0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(0, 99) < 60);
        end
        req_ready = rdy;
        if (rdy) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
          check_eq("req_inst", {1'b1, 9'h0, req_inst}, e);
          holding = 0;
          pend = int'($urandom_range(0, 3));
        end else begin
          holding = 1;
          held = 32'(req_inst);
          if ($urandom_range(0, 3) == 0) conv_done = 1'b1;
        end
      end else begin
        holding = 0;
        req_ready = 1'($urandom_range(0, 1));
      end
    end
    check_eq("frame_complete", 32'(done), 32'd1);
    check_eq("next_matrix_cnt", 32'(nm), 32'(W * H));
    check_eq("frame_done_cnt", 32'(fd), 32'd1);
    check_eq("model_drained", 32'(exp_q.size()), 32'd0);
    conv_done = 1'b0;
    req_ready = 1'b0;
    @(negedge clk);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("no_retrigger", 32'(busy), 32'd0);
    start = 1'b0;
    $display("frame ks=%0d opc=%b cycles=%0d next_matrix=%0d frame_done=%0d", ks, opc, cyc, nm, fd);
  endtask

  task automatic abort_test();
    bit got = 0;
    @(negedge clk);
    start = 1'b0; ksize = 2'd0; opcode_in = OPC_CONV_ROB;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_valid) begin
        got = 1;
        break;
      end
    end
    check_eq("abort_reach_issue", 32'(got), 32'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check_eq("abort_wait_noreq", 32'(req_valid), 32'd0);
    check_eq("abort_wait_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    conv_done = 1'b1;
    @(negedge clk);
    check_eq("abort_no_matrix", 32'(next_matrix), 32'd0);
    check_eq("abort_idle", 32'(busy), 32'd0);
    abort = 1'b0;
    conv_done = 1'b0;
    @(negedge clk);
    check_eq("abort_still_idle", 32'(busy), 32'd0);
    check_eq("abort_inst_clr", 32'(req_inst), 32'd0);
    start = 1'b0;
    $display("abort in WAIT_DONE with same-cycle conv_done");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; opcode_in = '0; ksize = '0;
    req_ready = 1'b0; conv_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_buf_load", 32'(buf_load), 32'd0);
    check_eq("rst_buf_start", 32'(buf_start), 32'd0);
    check_eq("rst_buf_addr", 32'(buf_addr), 32'd0);
    check_eq("rst_req_valid", 32'(req_valid), 32'd0);
    check_eq("rst_req_inst", 32'(req_inst), 32'd0);
    check_eq("rst_next_matrix", 32'(next_matrix), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    $display("reset released");

    run_frame(1, OPC_CONV, 1'b1);
    abort_test();
    run_frame(int'($urandom_range(0, 2)), opc_tab[$urandom_range(0, 4)], 1'b0);
    for (int f = 0; f < 3; f++)
      run_frame(int'($urandom_range(0, 2)), opc_tab[$urandom_range(0, 4)], f == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
